// File: rtl/truth_table_sweeper.sv
// Drives all 8 input combinations of a 3-input gate, captures its output and assembles the truth-table code.
// Optional SWEEP_STABILITY_CHECK_EN adds the `unstable` output (gate_out disagreement within a settle window).
//
// state  | meaning
// IDLE   | inputs 000, waiting for start
// SETTLE | holding combination k, counting down the settle time
// SAMPLE | counter at 0: capture gate_out for combination k on this edge
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       match
`ifdef SWEEP_STABILITY_CHECK_EN
  ,
  output logic       unstable
`endif
);

  localparam int unsigned SC     = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0]  RELOAD = 8'(SC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  // A one-cycle settle has no countdown, so a loaded combination is sampled on the very next edge.
  localparam state_t LOAD_STATE = (SC == 1) ? SAMPLE : SETTLE;

  state_t     state, state_nxt;
  logic [2:0] k;
  logic [7:0] cnt;
  logic [7:0] shadow;
  logic [7:0] captured;
  logic       match_now;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_STATE;
      SETTLE: begin
        if (abort)            state_nxt = IDLE;
        else if (cnt == 8'd1) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort || k == 3'd7) state_nxt = IDLE;
        else                    state_nxt = LOAD_STATE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy                 = (state != IDLE);
    {in1, in2, in3}      = k;
    captured             = shadow;
    captured[3'd7 - k]   = gate_out;
  end

`ifdef SWEEP_STABILITY_CHECK_EN
  logic first_q;
  logic first_s;
  logic unstable_flag;

  // First settle edge of a combination is the one where the counter still holds its reload value.
  always_comb begin
    first_s   = (cnt == RELOAD) ? gate_out : first_q;
    match_now = (captured == EXPECTED) && !(unstable_flag || (first_s != gate_out));
  end
`else
  always_comb match_now = (captured == EXPECTED);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= 3'd0;
      cnt         <= 8'd0;
      shadow      <= 8'h00;
      truth_table <= 8'h00;
      match       <= 1'b0;
      done        <= 1'b0;
`ifdef SWEEP_STABILITY_CHECK_EN
      first_q       <= 1'b0;
      unstable_flag <= 1'b0;
      unstable      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k      <= 3'd0;
            cnt    <= RELOAD;
            shadow <= 8'h00;
`ifdef SWEEP_STABILITY_CHECK_EN
            unstable_flag <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (abort) begin
            k   <= 3'd0;
            cnt <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
`ifdef SWEEP_STABILITY_CHECK_EN
            if (cnt == RELOAD) first_q <= gate_out;
`endif
          end
        end
        SAMPLE: begin
          if (abort) begin
            k   <= 3'd0;
            cnt <= 8'd0;
          end else begin
            shadow <= captured;
`ifdef SWEEP_STABILITY_CHECK_EN
            if (first_s != gate_out) unstable_flag <= 1'b1;
`endif
            if (k == 3'd7) begin
              truth_table <= captured;
              match       <= match_now;
              done        <= 1'b1;
              k           <= 3'd0;
              cnt         <= 8'd0;
`ifdef SWEEP_STABILITY_CHECK_EN
              unstable    <= unstable_flag || (first_s != gate_out);
`endif
            end else begin
              k   <= k + 3'd1;
              cnt <= RELOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised self-checking bench for truth_table_sweeper against a lookup-table gate model.
// Define SWEEP_STABILITY_CHECK_EN to also exercise the `unstable` output.
module tb_truth_table_sweeper;

  localparam int S = 4;
  localparam int N = 8 * S;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       in1, in2, in3, gate_out;
  logic       busy, done, match;
  logic [7:0] truth_table;
`ifdef SWEEP_STABILITY_CHECK_EN
  logic       unstable;
`endif

  bit   lut [8];
  logic glitch;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_tt;
  logic       exp_match;

  truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(8'h16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in1(in1), .in2(in2), .in3(in3), .gate_out(gate_out),
    .busy(busy), .done(done), .truth_table(truth_table), .match(match)
`ifdef SWEEP_STABILITY_CHECK_EN
    , .unstable(unstable)
`endif
  );

  always #5 clk = ~clk;

  always_comb gate_out = lut[{in1, in2, in3}] ^ glitch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truth-table code: combination k's output lands at bit weight 2^(7-k).
  function automatic logic [7:0] model_code();
    int v = 0;
    for (int kk = 0; kk < 8; kk++) if (lut[kk]) v += 1 << (7 - kk);
    return 8'(v);
  endfunction

  task automatic load_two_high();
    for (int kk = 0; kk < 8; kk++) lut[kk] = ($countones(3'(kk)) == 2);
  endtask

  task automatic load_random();
    for (int kk = 0; kk < 8; kk++) lut[kk] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_sweep(input int abort_at, input int extra_start_at, input bit glitch_c3);
    logic [7:0] want;
    want = model_code();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_inputs", 32'({in1, in2, in3}), 32'd0);
    chk("e0_done", 32'(done), 32'd0);
    for (int cyc = 1; cyc <= N; cyc++) begin
      @(negedge clk);
      start  = (cyc == extra_start_at);
      abort  = (cyc == abort_at);
      glitch = glitch_c3 && (cyc == 3 * S + 1);
      @(posedge clk); #1;
      if (cyc == abort_at) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_inputs", 32'({in1, in2, in3}), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_tt", 32'(truth_table), 32'(exp_tt));
        chk("abort_match", 32'(match), 32'(exp_match));
        @(negedge clk); abort = 1'b0; glitch = 1'b0; start = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done), 32'd0);
        end
        return;
      end else if (cyc < N) begin
        chk("step_inputs", 32'({in1, in2, in3}), 32'(cyc / S));
        chk("step_busy", 32'(busy), 32'd1);
        chk("step_done", 32'(done), 32'd0);
      end else begin
        exp_tt    = want;
        exp_match = (want == 8'h16) && !glitch_c3;
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_inputs", 32'({in1, in2, in3}), 32'd0);
        chk("end_tt", 32'(truth_table), 32'(exp_tt));
        chk("end_match", 32'(match), 32'(exp_match));
`ifdef SWEEP_STABILITY_CHECK_EN
        chk("end_unstable", 32'(unstable), 32'(glitch_c3));
`endif
      end
    end
    start = 1'b0; abort = 1'b0; glitch = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b1; glitch = 1'b0;
    for (int kk = 0; kk < 8; kk++) lut[kk] = 1'b0;
    exp_tt = 8'h00; exp_match = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inputs", 32'({in1, in2, in3}), 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_inputs", 32'({in1, in2, in3}), 32'd0);
      chk("idle_tt", 32'(truth_table), 32'd0);
      chk("idle_match", 32'(match), 32'd0);
    end

    load_two_high();
    run_sweep(0, 0, 1'b0);
    for (int kk = 0; kk < 8; kk++) lut[kk] = 1'b1;
    run_sweep(0, 0, 1'b0);

    load_two_high();
    run_sweep(0, 0, 1'b0);
    load_random();
    run_sweep(13, 0, 1'b0);

    // Stray start mid-sweep, then back-to-back restart in the done cycle.
    load_two_high();
    run_sweep(0, 5, 1'b0);
    load_random();
    run_sweep(0, 0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      load_random();
      run_sweep(0, 0, 1'b0);
    end

`ifdef SWEEP_STABILITY_CHECK_EN
    load_two_high();
    run_sweep(0, 0, 1'b1);
    run_sweep(0, 0, 1'b0);
`endif

    // Reset in the middle of a sweep discards everything.
    load_random();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_inputs", 32'({in1, in2, in3}), 32'd0);
    chk("midrst_tt", 32'(truth_table), 32'd0);
    chk("midrst_match", 32'(match), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
